// File: rtl/mult_share_arb_pkg.sv
// rtl/mult_share_arb_pkg.sv - shared types and constants for the multiplier-sharing arbiter
//
// Purpose : FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), operand and
//           product widths, the largest supported requester count, and a
//           one-hot to index helper used for the round-robin pointer update.
// Ports   : none (package).
package mult_share_arb_pkg;

  localparam int OPND_W  = 8;
  localparam int PROD_W  = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
  function automatic int onehot_index(input logic [MAX_REQ-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin selector
//
// Purpose : choose the first asserted request at or after ptr, wrapping
//           modulo NUM_REQ.
// Ports   : req  [NUM_REQ-1:0] in   request levels
//           ptr  [PTR_W-1:0]   in   highest-priority index (0..NUM_REQ-1)
//           pick [NUM_REQ-1:0] out  one-hot winner, all-zero when idle
//           any                out  at least one request is asserted
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic w_found;

  assign any = |req;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!w_found && req[(int'(ptr) + o) % NUM_REQ]) begin
        pick[(int'(ptr) + o) % NUM_REQ] = 1'b1;
        w_found                         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin sharing of one sequential 8x8 multiplier
//
// Purpose : accepts one request at a time from NUM_REQ clients, latches the
//           winner's operands, pulses mult_start, waits for the rising edge of
//           mult_done and returns the 16-bit product to the granted client.
// Option  : MULT_ARB_TIMEOUT_EN - compiles in a WAIT watchdog; after
//           TIMEOUT_CYCLES WAIT cycles without completion the transaction ends
//           with rsp_product = 0 and rsp_err = 1. Undefined: rsp_err is 0 and
//           WAIT has no limit.
// Ports   : clk, reset_a (async, active-low)
//           req[NUM_REQ], req_a/req_b[NUM_REQ*8]  client requests and operands
//           gnt[NUM_REQ]        one-cycle accept pulse (ISSUE)
//           rsp_valid[NUM_REQ]  one-cycle result pulse (RESP)
//           rsp_product[16], rsp_err  result, held until next capture
//           busy                state other than IDLE
//           mult_dataa/datab[8], mult_start  to the multiplier
//           mult_product[16], mult_done      from the multiplier
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset_a,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*OPND_W-1:0] req_a,
  input  logic [NUM_REQ*OPND_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [PROD_W-1:0]         rsp_product,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [OPND_W-1:0]         mult_dataa,
  output logic [OPND_W-1:0]         mult_datab,
  output logic                      mult_start,
  input  logic [PROD_W-1:0]         mult_product,
  input  logic                      mult_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mult_share_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  arb_state_t          r_state;
  logic [PTR_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_sel;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [PROD_W-1:0]   r_rsp_product;
  logic [OPND_W-1:0]   r_dataa;
  logic [OPND_W-1:0]   r_datab;
  logic                r_start;
  logic                r_done_q;

  logic [NUM_REQ-1:0]  w_pick;
  logic                w_any;
  logic [OPND_W-1:0]   w_sel_a;
  logic [OPND_W-1:0]   w_sel_b;
  logic                w_done_edge;
  logic [PTR_W-1:0]    w_next_ptr;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req  (req),
    .ptr  (r_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  // AND-OR mux of the winner's operands; w_pick is one-hot or zero.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_sel_a = w_sel_a | req_a[i*OPND_W +: OPND_W];
        w_sel_b = w_sel_b | req_b[i*OPND_W +: OPND_W];
      end
    end
  end

  // Priority moves to the requester just after the one being served.
  always_comb begin
    w_next_ptr = PTR_W'((onehot_index(MAX_REQ'(r_sel)) + 1) % NUM_REQ);
  end

  // Only a low-to-high transition completes; a done level still high from a
  // previous operation is ignored.
  assign w_done_edge = mult_done & ~r_done_q;

  assign busy        = (r_state != ST_IDLE);
  assign gnt         = r_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_product = r_rsp_product;
  assign mult_dataa  = r_dataa;
  assign mult_datab  = r_datab;
  assign mult_start  = r_start;

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_sel         <= '0;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_product <= '0;
      r_dataa       <= '0;
      r_datab       <= '0;
      r_start       <= 1'b0;
      r_done_q      <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_rsp_err     <= 1'b0;
`endif
    end else begin
      r_done_q    <= mult_done;
      // Pulse outputs default low; each is raised for one state only.
      r_gnt       <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= '0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick;
            r_dataa <= w_sel_a;
            r_datab <= w_sel_b;
            r_gnt   <= w_pick;
            r_start <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (w_done_edge) begin
            r_rsp_product <= mult_product;
            r_rsp_valid   <= r_sel;
            r_state       <= ST_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
            r_rsp_err     <= 1'b0;
`endif
          end
`ifdef MULT_ARB_TIMEOUT_EN
          // r_wait_cnt counts completed WAIT cycles before this one.
          else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_product <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_valid   <= r_sel;
            r_state       <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end

        ST_RESP: begin
          r_ptr   <= w_next_ptr;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized self-checking bench for mult_share_arb
module tb_mult_share_arb;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            reset_a;
  logic [N-1:0]    req;
  logic [N*8-1:0]  req_a, req_b;
  logic [N-1:0]    gnt, rsp_valid;
  logic [15:0]     rsp_product;
  logic            rsp_err, busy;
  logic [7:0]      mult_dataa, mult_datab;
  logic            mult_start;
  logic [15:0]     mult_product;
  logic            mult_done;

  always #5 clk = ~clk;

  mult_share_arb #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset_a      (reset_a),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_product  (rsp_product),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .mult_dataa   (mult_dataa),
    .mult_datab   (mult_datab),
    .mult_start   (mult_start),
    .mult_product (mult_product),
    .mult_done    (mult_done)
  );

  // ---------------- stub multiplier ----------------
  // done appears st_lat edges after the edge that samples start.
  // mode 0: done pulse; mode 1: done level, dropped when start is sampled;
  // mode 2: done level, still high one cycle into WAIT (needs st_lat >= 2).
  int       st_lat   = 3;
  int       st_mode  = 0;
  bit       st_never = 1'b0;
  logic [7:0] s_a, s_b;
  int       s_cnt;
  bit       s_drop;

  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      mult_done    <= 1'b0;
      mult_product <= 16'h0;
      s_cnt        <= 0;
      s_drop       <= 1'b0;
      s_a          <= 8'h0;
      s_b          <= 8'h0;
    end else begin
      if (st_mode == 0 && mult_done) mult_done <= 1'b0;
      if (s_drop) begin
        mult_done <= 1'b0;
        s_drop    <= 1'b0;
      end
      if (mult_start) begin
        s_a   <= mult_dataa;
        s_b   <= mult_datab;
        s_cnt <= st_never ? 0 : st_lat;
        if (st_mode == 2) s_drop <= 1'b1;
        else              mult_done <= 1'b0;
      end else if (s_cnt == 1) begin
        mult_done    <= 1'b1;
        mult_product <= 16'(s_a) * 16'(s_b);
        s_cnt        <= 0;
      end else if (s_cnt > 1) begin
        s_cnt <= s_cnt - 1;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Transaction timeline: accepted at an idle edge -> grant/start in the next
  // cycle g, response in cycle g + L + 2, idle again afterwards.
  int         cyc       = 0;
  int         m_gnt_cyc = -100;
  int         m_rsp_cyc = -100;
  int         m_win     = 0;
  int         m_ptr     = 0;
  int         m_a       = 0;
  int         m_b       = 0;
  bit         m_tmo     = 1'b0;
  bit         m_found;
  logic [15:0] exp_prod = 16'h0;
  bit         exp_err   = 1'b0;
  logic [7:0] exp_a     = 8'h0;
  logic [7:0] exp_b     = 8'h0;

  always @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      m_gnt_cyc = -100;
      m_rsp_cyc = -100;
      m_ptr     = 0;
      m_win     = 0;
      exp_prod  = 16'h0;
      exp_err   = 1'b0;
      exp_a     = 8'h0;
      exp_b     = 8'h0;
    end else begin
      cyc = cyc + 1;
      if ((cyc - 1) > m_rsp_cyc && req != '0) begin
        m_found = 1'b0;
        for (int o = 0; o < N; o++) begin
          if (!m_found && req[(m_ptr + o) % N]) begin
            m_win   = (m_ptr + o) % N;
            m_found = 1'b1;
          end
        end
        m_a       = int'(req_a[m_win*8 +: 8]);
        m_b       = int'(req_b[m_win*8 +: 8]);
        exp_a     = 8'(m_a);
        exp_b     = 8'(m_b);
        m_gnt_cyc = cyc;
        m_ptr     = (m_win + 1) % N;
        if (st_never) begin
`ifdef MULT_ARB_TIMEOUT_EN
          m_rsp_cyc = cyc + 1 + TMO;
          m_tmo     = 1'b1;
`else
          m_rsp_cyc = 1 << 30;
          m_tmo     = 1'b0;
`endif
        end else begin
          m_rsp_cyc = cyc + st_lat + 2;
          m_tmo     = 1'b0;
        end
      end
      if (cyc == m_rsp_cyc) begin
        exp_prod = m_tmo ? 16'h0 : 16'(m_a * m_b);
        exp_err  = m_tmo;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  int log_idx[$];
  int log_prod[$];
  int log_err[$];
  int log_cyc[$];
  int gnt_cnt[N];
  int start_cnt, rsp_cnt;
  logic [N-1:0] eg, ev;
  bit eb;

  always @(negedge clk) begin
    eg = '0;
    ev = '0;
    if (cyc == m_gnt_cyc) eg[m_win] = 1'b1;
    if (cyc == m_rsp_cyc) ev[m_win] = 1'b1;
    eb = (cyc >= m_gnt_cyc) && (cyc <= m_rsp_cyc);
    chk("gnt",         32'(gnt),         32'(eg));
    chk("mult_start",  32'(mult_start),  32'(cyc == m_gnt_cyc));
    chk("rsp_valid",   32'(rsp_valid),   32'(ev));
    chk("busy",        32'(busy),        32'(eb));
    chk("rsp_product", 32'(rsp_product), 32'(exp_prod));
    chk("mult_dataa",  32'(mult_dataa),  32'(exp_a));
    chk("mult_datab",  32'(mult_datab),  32'(exp_b));
    if (ev != '0) chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_cnt[i]++;
      if (rsp_valid[i]) begin
        log_idx.push_back(i);
        log_prod.push_back(int'(rsp_product));
        log_err.push_back(int'(rsp_err));
        log_cyc.push_back(cyc);
      end
    end
    if (mult_start) start_cnt++;
    if (rsp_valid != '0) rsp_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  logic [N-1:0] hold;

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gnt[i] && !hold[i]) req[i] = 1'b0;
    end
  endtask

  task automatic raise(input int i, input int a, input int b);
    req[i]          = 1'b1;
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_prod.delete();
    log_err.delete();
    log_cyc.delete();
    for (int i = 0; i < N; i++) gnt_cnt[i] = 0;
    start_cnt = 0;
    rsp_cnt   = 0;
  endtask

  task automatic wait_rsp(input string nm, input int n, input int budget);
    int b;
    b = 0;
    while (log_idx.size() < n && b < budget) begin
      step();
      b++;
    end
    chk({nm, "_rsp_count"}, 32'(log_idx.size()), 32'(n));
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int b;
    b = 0;
    while ((busy || req != '0) && b < budget) begin
      step();
      b++;
    end
    chk({nm, "_idle"}, 32'({busy, req}), 32'(0));
  endtask

  task automatic check_log(input string nm, input int k, input int idx, input int prod);
    if (k < log_idx.size()) begin
      chk({nm, "_idx"},  32'(log_idx[k]),  32'(idx));
      chk({nm, "_prod"}, 32'(log_prod[k]), 32'(prod));
    end else begin
      chk({nm, "_missing"}, 32'(log_idx.size()), 32'(k + 1));
    end
  endtask

  task automatic do_reset();
    reset_a = 1'b0;
    req     = '0;
    step();
    step();
    reset_a = 1'b1;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_gnt"},       32'(gnt),         32'(0));
    chk({nm, "_rsp_valid"}, 32'(rsp_valid),   32'(0));
    chk({nm, "_product"},   32'(rsp_product), 32'(0));
    chk({nm, "_err"},       32'(rsp_err),     32'(0));
    chk({nm, "_busy"},      32'(busy),        32'(0));
    chk({nm, "_dataa"},     32'(mult_dataa),  32'(0));
    chk({nm, "_datab"},     32'(mult_datab),  32'(0));
    chk({nm, "_start"},     32'(mult_start),  32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual %0d required %0d", cyc, 0);
    $fatal(1);
  end

  int t0;
  int ra, rb;

  initial begin
    reset_a = 1'b0;
    req     = '0;
    req_a   = '0;
    req_b   = '0;
    hold    = '0;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset_a = 1'b1;
    step();

    // requester 0 alone: 11 x 85 = 935, latency L+3 = 6
    st_lat  = 3;
    st_mode = 0;
    clear_log();
    raise(0, 11, 85);
    t0 = cyc;
    wait_rsp("t1", 1, 40);
    check_log("t1", 0, 0, 935);
    if (log_cyc.size() > 0) chk("t1_latency", 32'(log_cyc[0] - t0), 32'(6));
    wait_idle("t1", 20);
    chk("t1_gnt_pulses",   32'(gnt_cnt[0]), 32'(1));
    chk("t1_start_pulses", 32'(start_cnt),  32'(1));

    // all four at once after reset: order 0..3, products 10..40
    do_reset();
    st_lat  = 2;
    st_mode = 1;
    clear_log();
    for (int i = 0; i < N; i++) raise(i, i + 1, 10);
    wait_rsp("t2", 4, 100);
    for (int k = 0; k < 4; k++) check_log("t2", k, k, 10 * (k + 1));
    wait_idle("t2", 40);

    // req 0 and 2 held: grants alternate 0,2,0,2
    st_lat  = 1;
    st_mode = 0;
    clear_log();
    hold = 4'b0101;
    raise(0, 12, 13);
    raise(2, 200, 3);
    wait_rsp("t3", 4, 100);
    hold = '0;
    check_log("t3a", 0, 0, 156);
    check_log("t3b", 1, 2, 600);
    check_log("t3c", 2, 0, 156);
    check_log("t3d", 3, 2, 600);
    wait_idle("t3", 60);

    // boundaries, with done left high between operations
    st_lat  = 4;
    st_mode = 2;
    clear_log();
    raise(1, 255, 255);
    wait_rsp("t4a", 1, 40);
    wait_idle("t4a", 20);
    chk("t4_done_stale_high", 32'(mult_done), 32'(1));
    raise(3, 0, 200);
    t0 = cyc;
    wait_rsp("t4b", 2, 40);
    check_log("t4a", 0, 1, 16'hFE01);
    check_log("t4b", 1, 3, 0);
    if (log_cyc.size() > 1) chk("t4b_latency", 32'(log_cyc[1] - t0), 32'(7));
    wait_idle("t4b", 20);

    // reset during WAIT, then 3 x 7
    st_lat  = 6;
    st_mode = 0;
    clear_log();
    raise(1, 9, 9);
    step();
    step();
    step();
    reset_a = 1'b0;
    @(negedge clk);
    check_all_zero("t5_abort");
    step();
    step();
    reset_a = 1'b1;
    repeat (10) step();
    chk("t5_no_rsp", 32'(rsp_cnt), 32'(0));
    raise(2, 3, 7);
    wait_rsp("t5", 1, 40);
    check_log("t5", 0, 2, 21);
    wait_idle("t5", 20);

    // randomized traffic in blocks with fixed multiplier behaviour
    for (int blk = 0; blk < 6; blk++) begin
      st_lat  = $urandom_range(2, 8);
      st_mode = $urandom_range(0, 2);
      for (int s = 0; s < 80; s++) begin
        step();
        for (int i = 0; i < N; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
              0:       ra = 255;
              1:       ra = 0;
              default: ra = $urandom_range(0, 255);
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255);
            raise(i, ra, rb);
          end
        end
      end
      wait_idle("rand", 400);
    end

    // multiplier never completes
    st_never = 1'b1;
    st_mode  = 0;
    clear_log();
    raise(0, 5, 5);
    t0 = cyc;
`ifdef MULT_ARB_TIMEOUT_EN
    wait_rsp("t7", 1, 60);
    check_log("t7", 0, 0, 0);
    if (log_err.size() > 0) chk("t7_err", 32'(log_err[0]), 32'(1));
    if (log_cyc.size() > 0) chk("t7_latency", 32'(log_cyc[0] - t0), 32'(18));
    wait_idle("t7", 20);
`else
    repeat (40) step();
    chk("t7_busy_stuck", 32'(busy), 32'(1));
    chk("t7_no_rsp", 32'(rsp_cnt), 32'(0));
    do_reset();
`endif
    st_never = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
